// File: rtl/fc_bias_pkg.sv
// Shared types and helpers for the parallel FC bias buffer.
// Optional lane shift/saturate is enabled by defining FC_BIAS_SHIFT_EN.
package fc_bias_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Signed saturation limits for an ow-bit lane
    function automatic longint sat_max(input int ow);
        return (longint'(1) <<< (ow - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

endpackage

// File: rtl/bias_lane_fmt.sv
// One output lane: sign extension, optional shift/saturate (FC_BIAS_SHIFT_EN),
// and zeroing of lanes beyond the last neuron.
module bias_lane_fmt
    import fc_bias_pkg::*;
#(
    parameter int WD = 8,
    parameter int OW = 16
) (
    input  logic [WD-1:0] i_data,
    input  logic          i_vld,
`ifdef FC_BIAS_SHIFT_EN
    input  logic [3:0]    i_shift,
`endif
    output logic [OW-1:0] o_lane
);

    logic signed [WD-1:0] data_s;
    logic signed [OW-1:0] ext;

    assign data_s = i_data;
    assign ext    = OW'(data_s);

`ifdef FC_BIAS_SHIFT_EN
    // 15 guard bits hold any shift of up to 15 without losing the sign
    localparam logic signed [OW+14:0] SAT_HI = (OW+15)'(sat_max(OW));
    localparam logic signed [OW+14:0] SAT_LO = (OW+15)'(sat_min(OW));

    logic signed [OW+14:0] wide;
    logic signed [OW-1:0]  sat;

    assign wide = (OW+15)'(ext) <<< i_shift;

    always_comb begin
        sat = OW'(wide);
        if (wide > SAT_HI)
            sat = OW'(SAT_HI);
        else if (wide < SAT_LO)
            sat = OW'(SAT_LO);
    end

    assign o_lane = i_vld ? sat : '0;
`else
    assign o_lane = i_vld ? ext : '0;
`endif

endmodule

// File: rtl/buffer_fc_bias_par.sv
// Loads NUM signed biases once and replays them as PAR-lane ready/valid beats.
// Define FC_BIAS_SHIFT_EN to add the i_shift port with saturating left shift.
module buffer_fc_bias_par
    import fc_bias_pkg::*;
#(
    parameter int WD  = 8,
    parameter int OW  = 16,
    parameter int NUM = 10,
    parameter int PAR = 2,
    parameter int IW  = 8
) (
    input  logic              i_sclk,
    input  logic              i_rstn,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [WD-1:0]     i_wr_data,
    output logic              o_load_done,
    output logic              o_wr_err,
    input  logic              i_rd_start,
    input  logic              i_rd_ready,
`ifdef FC_BIAS_SHIFT_EN
    input  logic [3:0]        i_shift,
`endif
    output logic              o_b_en,
    output logic [IW-1:0]     o_b_num,
    output logic              o_b_last,
    output logic [PAR-1:0]    o_lane_vld,
    output logic [PAR*OW-1:0] o_bias,
    output logic              o_busy
);

    localparam int NBEATS    = ceil_div(NUM, PAR);
    localparam int LAST_BASE = (NBEATS - 1) * PAR;
    localparam int AW        = (NUM > 1) ? $clog2(NUM) : 1;

    state_t               state;
    logic [AW-1:0]        wr_ptr;
    logic [IW-1:0]        base_q;
    logic [WD-1:0]        mem [NUM];

    logic                 start;
    logic                 load_beat;
    logic [IW-1:0]        nxt_base;
    logic [PAR-1:0]       lane_vld;
    logic [PAR*OW-1:0]    lane_bias;

    assign start = (state == ST_READY) && i_rd_start;

    // Selects which beat (if any) gets registered onto the outputs this edge
    always_comb begin
        load_beat = 1'b0;
        nxt_base  = base_q;
        if (start) begin
            load_beat = 1'b1;
            nxt_base  = '0;
        end else if (state == ST_READ && o_b_en && i_rd_ready && !o_b_last) begin
            load_beat = 1'b1;
            nxt_base  = base_q + IW'(PAR);
        end
    end

`ifdef FC_BIAS_SHIFT_EN
    logic [3:0] shift_q;
    logic [3:0] shift_nxt;
    assign shift_nxt = start ? i_shift : shift_q;

    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn)
            shift_q <= '0;
        else if (start)
            shift_q <= i_shift;
    end
`endif

    for (genvar i = 0; i < PAR; i++) begin : g_lane
        logic [IW:0]   lane_idx;
        logic [WD-1:0] lane_raw;

        assign lane_idx    = {1'b0, nxt_base} + (IW+1)'(i);
        assign lane_vld[i] = lane_idx < (IW+1)'(NUM);
        assign lane_raw    = lane_vld[i] ? mem[lane_idx[AW-1:0]] : '0;

        bias_lane_fmt #(.WD(WD), .OW(OW)) u_fmt (
            .i_data  (lane_raw),
            .i_vld   (lane_vld[i]),
`ifdef FC_BIAS_SHIFT_EN
            .i_shift (shift_nxt),
`endif
            .o_lane  (lane_bias[i*OW +: OW])
        );
    end

    // NOTE: the bias array has no reset; its contents are only read after a full load.
    always_ff @(posedge i_sclk) begin
        if (!i_clr && i_wr_en && (state == ST_IDLE || state == ST_LOAD))
            mem[wr_ptr] <= i_wr_data;
    end

    // NOTE: all state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_sclk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            base_q      <= '0;
            o_load_done <= 1'b0;
            o_wr_err    <= 1'b0;
            o_b_en      <= 1'b0;
            o_b_num     <= '0;
            o_b_last    <= 1'b0;
            o_lane_vld  <= '0;
            o_bias      <= '0;
            o_busy      <= 1'b0;
        end else if (i_clr) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            base_q      <= '0;
            o_load_done <= 1'b0;
            o_wr_err    <= 1'b0;
            o_b_en      <= 1'b0;
            o_b_num     <= '0;
            o_b_last    <= 1'b0;
            o_lane_vld  <= '0;
            o_bias      <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_wr_err <= 1'b0;
            case (state)
                ST_IDLE, ST_LOAD: begin
                    if (i_wr_en) begin
                        if (wr_ptr == AW'(NUM - 1)) begin
                            wr_ptr      <= '0;
                            state       <= ST_READY;
                            o_load_done <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + AW'(1);
                            state  <= ST_LOAD;
                        end
                    end
                end
                ST_READY: begin
                    o_wr_err <= i_wr_en;
                    if (i_rd_start) begin
                        state  <= ST_READ;
                        o_busy <= 1'b1;
                    end
                end
                ST_READ: begin
                    o_wr_err <= i_wr_en;
                    if (o_b_en && i_rd_ready && o_b_last) begin
                        state      <= ST_READY;
                        o_busy     <= 1'b0;
                        o_b_en     <= 1'b0;
                        o_b_num    <= '0;
                        o_b_last   <= 1'b0;
                        o_lane_vld <= '0;
                        o_bias     <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (load_beat) begin
                o_b_en     <= 1'b1;
                base_q     <= nxt_base;
                o_b_num    <= nxt_base + IW'(1);
                o_b_last   <= (nxt_base == IW'(LAST_BASE));
                o_lane_vld <= lane_vld;
                o_bias     <= lane_bias;
            end
        end
    end

endmodule

// File: tb/tb_buffer_fc_bias_par.sv
// Self-checking bench for buffer_fc_bias_par (NUM=10, PAR=4); covers the
// FC_BIAS_SHIFT_EN lanes as well when that macro is defined.
module tb_buffer_fc_bias_par;

    localparam int WD  = 8;
    localparam int OW  = 16;
    localparam int NUM = 10;
    localparam int PAR = 4;
    localparam int IW  = 8;
    localparam int NB  = (NUM + PAR - 1) / PAR;

    typedef struct {
        logic [IW-1:0]     num;
        logic              last;
        logic [PAR-1:0]    vld;
        logic [PAR*OW-1:0] bias;
    } beat_t;

    logic              i_sclk = 1'b0;
    logic              i_rstn;
    logic              i_clr;
    logic              i_wr_en;
    logic [WD-1:0]     i_wr_data;
    logic              o_load_done;
    logic              o_wr_err;
    logic              i_rd_start;
    logic              i_rd_ready;
`ifdef FC_BIAS_SHIFT_EN
    logic [3:0]        i_shift;
`endif
    logic              o_b_en;
    logic [IW-1:0]     o_b_num;
    logic              o_b_last;
    logic [PAR-1:0]    o_lane_vld;
    logic [PAR*OW-1:0] o_bias;
    logic              o_busy;

    int                n_pass = 0;
    int                n_total = 0;
    int                model_mem [NUM];
    int                cur_shift = 0;
    beat_t             exp_q [$];
    beat_t             tbl [NB];
    logic [PAR*OW-1:0] first_bias;

    buffer_fc_bias_par #(.WD(WD), .OW(OW), .NUM(NUM), .PAR(PAR), .IW(IW)) dut (
        .i_sclk      (i_sclk),
        .i_rstn      (i_rstn),
        .i_clr       (i_clr),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .o_load_done (o_load_done),
        .o_wr_err    (o_wr_err),
        .i_rd_start  (i_rd_start),
        .i_rd_ready  (i_rd_ready),
`ifdef FC_BIAS_SHIFT_EN
        .i_shift     (i_shift),
`endif
        .o_b_en      (o_b_en),
        .o_b_num     (o_b_num),
        .o_b_last    (o_b_last),
        .o_lane_vld  (o_lane_vld),
        .o_bias      (o_bias),
        .o_busy      (o_busy)
    );

    always #5 i_sclk = ~i_sclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wr(input int v);
        i_wr_en   = 1'b1;
        i_wr_data = WD'(v);
        @(negedge i_sclk);
        i_wr_en   = 1'b0;
    endtask

    // Loads NUM values base, base+step, ... (value 0 optionally overridden) into DUT and model
    task automatic load_all(input int base, input int step, input int v0);
        for (int i = 0; i < NUM; i++) begin
            model_mem[i] = (i == 0) ? v0 : base + i * step;
            if (i == NUM - 1)
                check("load_done_before_last", {63'd0, o_load_done}, 64'd0);
            wr(model_mem[i]);
        end
        check("load_done", {63'd0, o_load_done}, 64'd1);
    endtask

    function automatic void push_model();
        for (int k = 0; k < NB; k++) begin
            beat_t b;
            b.num  = IW'(k * PAR + 1);
            b.last = (k == NB - 1);
            b.vld  = '0;
            b.bias = '0;
            for (int i = 0; i < PAR; i++) begin
                int idx;
                longint v;
                idx = k * PAR + i;
                if (idx < NUM) begin
                    v = longint'(model_mem[idx]) <<< cur_shift;
                    if (v > 32767)  v = 32767;
                    if (v < -32768) v = -32768;
                    b.vld[i] = 1'b1;
                    b.bias[i*OW +: OW] = OW'(v);
                end
            end
            exp_q.push_back(b);
        end
    endfunction

    // Starts a pass and checks every presented beat against the scoreboard head
    task automatic run_pass(input int stall_beat, input int stall_n);
        int  beat;
        int  held;
        int  budget;
        bit  first;
        beat = 0;
        held = 0;
        budget = 0;
        first = 1'b1;
        i_rd_ready = 1'b1;
        i_rd_start = 1'b1;
        @(negedge i_sclk);
        i_rd_start = 1'b0;
`ifdef FC_BIAS_SHIFT_EN
        i_shift = 4'd0;
`endif
        while (exp_q.size() > 0) begin
            budget++;
            if (!o_b_en || budget > 100) begin
                n_total++;
                $display("FAIL beat_stream: b_en=%0d at beat %0d, %0d beats outstanding",
                         o_b_en, beat, exp_q.size());
                exp_q.delete();
                break;
            end
            check("b_num",  {56'd0, o_b_num},     {56'd0, exp_q[0].num});
            check("b_last", {63'd0, o_b_last},    {63'd0, exp_q[0].last});
            check("lane_vld", {60'd0, o_lane_vld}, {60'd0, exp_q[0].vld});
            check("bias",   o_bias,               exp_q[0].bias);
            check("busy",   {63'd0, o_busy},      64'd1);
            if (first) begin
                first_bias = o_bias;
                first = 1'b0;
            end
            if (beat == stall_beat && held < stall_n) begin
                i_rd_ready = 1'b0;
                held++;
            end else begin
                i_rd_ready = 1'b1;
                void'(exp_q.pop_front());
                beat++;
            end
            @(negedge i_sclk);
        end
        i_rd_ready = 1'b1;
        check("b_en_after_pass", {63'd0, o_b_en}, 64'd0);
        check("busy_after_pass", {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        tbl[0].num = 8'd1; tbl[0].last = 1'b0; tbl[0].vld = 4'b1111; tbl[0].bias = 64'h0004_0003_0002_0001;
        tbl[1].num = 8'd5; tbl[1].last = 1'b0; tbl[1].vld = 4'b1111; tbl[1].bias = 64'h0008_0007_0006_0005;
        tbl[2].num = 8'd9; tbl[2].last = 1'b1; tbl[2].vld = 4'b0011; tbl[2].bias = 64'h0000_0000_000A_0009;

        i_rstn = 1'b0; i_clr = 1'b0; i_wr_en = 1'b0; i_wr_data = '0;
        i_rd_start = 1'b0; i_rd_ready = 1'b0;
`ifdef FC_BIAS_SHIFT_EN
        i_shift = 4'd0;
`endif
        #12;
        check("rst_b_en",      {63'd0, o_b_en},      64'd0);
        check("rst_load_done", {63'd0, o_load_done}, 64'd0);
        check("rst_wr_err",    {63'd0, o_wr_err},    64'd0);
        check("rst_busy",      {63'd0, o_busy},      64'd0);
        check("rst_b_num",     {56'd0, o_b_num},     64'd0);
        check("rst_bias",      o_bias,               64'd0);
        @(negedge i_sclk);
        i_rstn = 1'b1;

        // Plan vectors 1..10, expectations from the constant table
        load_all(1, 1, 1);
        for (int k = 0; k < NB; k++) exp_q.push_back(tbl[k]);
        run_pass(-1, 0);

        // Replay without reload, with backpressure on beat 1
        push_model();
        run_pass(1, 3);

        // Writes while READY are dropped and flagged
        i_wr_en = 1'b1; i_wr_data = 8'h55;
        @(negedge i_sclk);
        check("wr_err_1", {63'd0, o_wr_err}, 64'd1);
        i_wr_data = 8'hAA;
        @(negedge i_sclk);
        check("wr_err_2", {63'd0, o_wr_err}, 64'd1);
        i_wr_en = 1'b0;
        @(negedge i_sclk);
        check("wr_err_end", {63'd0, o_wr_err}, 64'd0);
        push_model();
        run_pass(-1, 0);

        // Clear from READY, rd_start ignored in IDLE, clear mid-LOAD beats a write
        i_clr = 1'b1;
        @(negedge i_sclk);
        i_clr = 1'b0;
        check("clr_load_done", {63'd0, o_load_done}, 64'd0);
        i_rd_start = 1'b1;
        @(negedge i_sclk);
        i_rd_start = 1'b0;
        check("idle_start_ignored", {63'd0, o_b_en}, 64'd0);
        for (int i = 0; i < 5; i++) wr(90 + i);
        i_clr = 1'b1; i_wr_en = 1'b1; i_wr_data = 8'h77;
        @(negedge i_sclk);
        i_clr = 1'b0; i_wr_en = 1'b0;
        check("clr_load_mid_done", {63'd0, o_load_done}, 64'd0);
        check("clr_load_mid_b_en", {63'd0, o_b_en},      64'd0);
        load_all(-5, 3, -3);
        push_model();
        run_pass(-1, 0);
        check("neg_bias_lane0", {48'd0, first_bias[15:0]}, 64'h0000_0000_0000_FFFD);

        // Clear mid-READ while beat 1 is being accepted
        i_rd_ready = 1'b1; i_rd_start = 1'b1;
        @(negedge i_sclk);
        i_rd_start = 1'b0;
        @(negedge i_sclk);
        check("read_beat1_num", {56'd0, o_b_num}, 64'd5);
        i_clr = 1'b1;
        @(negedge i_sclk);
        i_clr = 1'b0;
        check("clr_read_b_en",  {63'd0, o_b_en},      64'd0);
        check("clr_read_done",  {63'd0, o_load_done}, 64'd0);
        check("clr_read_busy",  {63'd0, o_busy},      64'd0);
        load_all(20, 1, 20);
        push_model();
        run_pass(-1, 0);

`ifdef FC_BIAS_SHIFT_EN
        // Saturating shift, i_shift changed after start must not matter
        i_clr = 1'b1;
        @(negedge i_sclk);
        i_clr = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            model_mem[i] = (i == 0) ? 100 : (i == 1) ? -100 : i;
            wr(model_mem[i]);
        end
        cur_shift = 9;
        i_shift = 4'd9;
        push_model();
        run_pass(-1, 0);
        check("shift_sat_hi", {48'd0, first_bias[15:0]},  64'h0000_0000_0000_7FFF);
        check("shift_sat_lo", {48'd0, first_bias[31:16]}, 64'h0000_0000_0000_8000);
        cur_shift = 0;
`endif

        // Asynchronous reset in the middle of a pass
        i_rd_ready = 1'b0; i_rd_start = 1'b1;
        @(negedge i_sclk);
        i_rd_start = 1'b0;
        check("pre_rst_b_en", {63'd0, o_b_en}, 64'd1);
        #2;
        i_rstn = 1'b0;
        #1;
        check("arst_b_en",      {63'd0, o_b_en},      64'd0);
        check("arst_bias",      o_bias,               64'd0);
        check("arst_b_num",     {56'd0, o_b_num},     64'd0);
        check("arst_lane_vld",  {60'd0, o_lane_vld},  64'd0);
        check("arst_busy",      {63'd0, o_busy},      64'd0);
        check("arst_load_done", {63'd0, o_load_done}, 64'd0);
        @(negedge i_sclk);
        i_rstn = 1'b1;
        @(negedge i_sclk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
